arb_requester: RTL and testbench
================================

// Module: arb_requester
// PURPOSE
//   Client-side agent for the shared-resource priority arbiter: one instance drives one r[i]/g[i] pair.
//   Accepts a burst command, raises req, waits for gnt, issues (len+1) beats while holding req, then drops req.
//   Before returning idle it waits for gnt to clear, so the arbiter always returns to its idle state between bursts.
//   Aborts with an error flag on a grant timeout or on a grant lost mid-burst.
// PARAMETERS
//   LEN_W     4    width of cmd_len; burst = cmd_len+1 beats (1..2^LEN_W)
//   WAIT_W    8    width of the grant-wait counter
//   MAX_WAIT  200  cycles in REQ before timeout abort; 0 disables timeout; must be < 2^WAIT_W
// PORTS
//   clk           in   1      single clock, all logic on posedge
//   resetn        in   1      synchronous, active-low reset
//   cmd_valid     in   1      burst command present
//   cmd_ready     out  1      block can accept a command (IDLE only)
//   cmd_len       in   LEN_W  beats-1, captured on accept
//   req           out  1      request to arbiter (its r[i])
//   gnt           in   1      grant from arbiter (its g[i]); registered, 1-cycle lag behind req
//   beat          out  1      one data beat in this cycle
//   beat_last     out  1      qualifies final beat of burst
//   busy          out  1      state != IDLE
//   done          out  1      1-cycle pulse: burst completed normally
//   err_timeout   out  1      1-cycle pulse: MAX_WAIT expired with no grant
//   err_gnt_lost  out  1      1-cycle pulse: gnt dropped while in OWN
// BEHAVIOUR
//   Reset (resetn=0 at posedge): state=IDLE, counters=0, len_q=0, done/err regs=0 => req=0, beat=0, busy=0, cmd_ready=1.
//   Reset mid-burst aborts silently: no done/err pulse, req low the cycle after reset edge.
//   States: IDLE, REQ, OWN, GAP (2-bit). Outputs decoded from state: req=(REQ|OWN), cmd_ready=IDLE, busy=!IDLE.
//   IDLE: cmd_valid -> capture len_q=cmd_len, wait_cnt=0, -> REQ. Else stay.
//   REQ : wait_cnt++ each cycle. gnt=1 -> OWN, beat_cnt=0 (gnt wins over a same-cycle timeout).
//         else MAX_WAIT!=0 && wait_cnt==MAX_WAIT-1 -> GAP, err_timeout pulse next cycle.
//   OWN : beat=gnt; beat_last=gnt && beat_cnt==len_q. On beat: beat_cnt++.
//         beat_last -> GAP, done pulse next cycle. gnt=0 -> GAP, no beat, err_gnt_lost pulse next cycle.
//   GAP : req=0, no beats; stay while gnt=1 (arbiter lag); gnt=0 -> IDLE. Min 1 cycle.
//   done/err_* are registered pulses; mutually exclusive; never asserted two consecutive cycles.
//   cmd_valid is ignored outside IDLE (no queueing); cmd_len sampled only on accept.
//   Latency, arbiter idle and uncontended: accept edge E0; req=1 in cycle 1; gnt=1 in cycle 2; beats in cycles 3..3+len;
//     req=0 in cycle 4+len; gnt=0 in cycle 5+len; cmd_ready=1 in cycle 6+len; done=1 in cycle 4+len.
//   Counters: beat_cnt LEN_W bits (never wraps: exit at ==len_q); wait_cnt WAIT_W bits, held (saturates) when MAX_WAIT=0.
//   Illegal state encodings recover to IDLE.
// STRUCTURE
//   arb_pkg: typedef enum logic [1:0] {REQ_IDLE, REQ_REQ, REQ_OWN, REQ_GAP} req_state_t; shared with arbiter bench.
//   Single module; no sub-module. Counters and pulse regs inline. Bench pairs 3 instances with the 3-way priority arbiter.
// TESTING
//   T1 single: len=3, arbiter idle -> req cycle 1, gnt cycle 2, beat cycles 3-6, beat_last cycle 6, done cycle 7, ready cycle 9.
//   T2 contention: 3 clients, cmd at same edge, len=1 each -> client1 bursts first, then 2, then 3; never two beats same cycle;
//      each req low >=1 cycle between bursts.
//   T3 timeout: MAX_WAIT=5, gnt tied 0 -> req high exactly 5 cycles, err_timeout 1 pulse, back in IDLE after 1 GAP cycle.
//   T4 grant lost: len=7, force gnt=0 after 2 beats -> beat stops same cycle, err_gnt_lost next cycle, done never asserts.
//   T5 reset mid-OWN: resetn=0 on beat 2 of len=5 -> req=0, beat=0, cmd_ready=1 next cycle; no done/err pulses.
//   T6 boundary: len=0 -> exactly 1 beat with beat_last=1; len=15 -> 16 beats; cmd_valid held during burst not re-accepted.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: requester state encoding shared by the requester RTL and the arbiter bench
package arb_pkg;
    typedef enum logic [1:0] {REQ_IDLE, REQ_REQ, REQ_OWN, REQ_GAP} req_state_t;
endpackage

// File: rtl/arb_requester.sv
// arb_requester: client-side burst agent driving one req/gnt pair of the shared priority arbiter
module arb_requester
    import arb_pkg::*;
#(
    parameter int LEN_W    = 4,
    parameter int WAIT_W   = 8,
    parameter int MAX_WAIT = 200
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             req,
    input  logic             gnt,
    output logic             beat,
    output logic             beat_last,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic             err_gnt_lost
);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT == 0 ? 0 : MAX_WAIT - 1);
    req_state_t        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d, beat_cnt_q, beat_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              done_q, done_d, err_to_q, err_to_d, err_lost_q, err_lost_d;

    assign cmd_ready    = state_q == REQ_IDLE;
    assign busy         = state_q != REQ_IDLE;
    assign req          = state_q == REQ_REQ || state_q == REQ_OWN;
    assign beat         = state_q == REQ_OWN && gnt;
    assign beat_last    = beat && beat_cnt_q == len_q;
    assign done         = done_q;
    assign err_timeout  = err_to_q;
    assign err_gnt_lost = err_lost_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        wait_cnt_d = wait_cnt_q;
        done_d     = 1'b0;
        err_to_d   = 1'b0;
        err_lost_d = 1'b0;
        case (state_q)
            REQ_IDLE: if (cmd_valid) begin
                state_d    = REQ_REQ;
                len_d      = cmd_len;
                wait_cnt_d = '0;
            end
            REQ_REQ: begin
                wait_cnt_d = &wait_cnt_q ? wait_cnt_q : wait_cnt_q + 1'b1;
                // a grant arriving on the timeout cycle still wins
                if (gnt) begin
                    state_d    = REQ_OWN;
                    beat_cnt_d = '0;
                end else if (MAX_WAIT != 0 && wait_cnt_q == WAIT_LAST) begin
                    state_d  = REQ_GAP;
                    err_to_d = 1'b1;
                end
            end
            REQ_OWN: if (!gnt) begin
                state_d    = REQ_GAP;
                err_lost_d = 1'b1;
            end else if (beat_cnt_q == len_q) begin
                state_d = REQ_GAP;
                done_d  = 1'b1;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
            REQ_GAP: state_d = gnt ? REQ_GAP : REQ_IDLE;
            default: state_d = REQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= REQ_IDLE;
            len_q      <= '0;
            beat_cnt_q <= '0;
            wait_cnt_q <= '0;
            done_q     <= 1'b0;
            err_to_q   <= 1'b0;
            err_lost_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            done_q     <= done_d;
            err_to_q   <= err_to_d;
            err_lost_q <= err_lost_d;
        end
    end
endmodule

// File: tb/tb_arb_requester.sv
// tb_arb_requester: three requesters on a behavioural 3-way priority arbiter plus one timeout-only requester
module tb_arb_requester;
    localparam int N = 4;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] cmd_valid = '0;
    logic [3:0]   cmd_len [N];
    logic [N-1:0] cmd_ready, req, gnt, beat, beat_last, busy, done, err_to, err_lost;
    logic [2:0]   grant = '0;
    logic         frc_en = 1'b0, frc_val = 1'b0;

    assign gnt = {1'b0, grant[2:1], frc_en ? frc_val : grant[0]};

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_dut
            arb_requester #(.LEN_W(4), .WAIT_W(8), .MAX_WAIT(i == 3 ? 5 : 200)) u_dut (
                .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid[i]), .cmd_ready(cmd_ready[i]),
                .cmd_len(cmd_len[i]), .req(req[i]), .gnt(gnt[i]), .beat(beat[i]),
                .beat_last(beat_last[i]), .busy(busy[i]), .done(done[i]),
                .err_timeout(err_to[i]), .err_gnt_lost(err_lost[i])
            );
        end
    endgenerate

    // Behavioural model: phase 0 idle, 1 asking, 2 transferring, 3 waiting for grant release.
    int ph [N];
    int nlen [N];
    int sent [N];
    int waited [N];
    int pend [N];
    int max_wait [N] = '{200, 200, 200, 5};

    always @(posedge clk) begin
        if (!resetn) grant <= 3'b000;
        else if (grant != 3'b000) grant <= ((grant & req[2:0]) != 3'b000) ? grant : 3'b000;
        else grant <= req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
        for (int k = 0; k < N; k++) begin
            pend[k] = 0;
            if (!resetn) ph[k] = 0;
            else if (ph[k] == 0) begin
                if (cmd_valid[k]) begin
                    nlen[k] = int'(cmd_len[k]) + 1;
                    waited[k] = 0;
                    ph[k] = 1;
                end
            end else if (ph[k] == 1) begin
                waited[k]++;
                if (gnt[k]) begin
                    ph[k] = 2;
                    sent[k] = 0;
                end else if (max_wait[k] != 0 && waited[k] >= max_wait[k]) begin
                    ph[k] = 3;
                    pend[k] = 2;
                end
            end else if (ph[k] == 2) begin
                if (!gnt[k]) begin
                    ph[k] = 3;
                    pend[k] = 3;
                end else begin
                    sent[k]++;
                    if (sent[k] == nlen[k]) begin
                        ph[k] = 3;
                        pend[k] = 1;
                    end
                end
            end else if (!gnt[k]) ph[k] = 0;
        end
    end

    int checks = 0, errors = 0, cyc = 0, c0 = 0;
    int n_beat [N], n_last [N], n_done [N], n_to [N], n_lost [N], n_req [N], n_acc [N];
    int t_req [N], t_gnt [N], t_ready [N], t_done [N], t_beat [N], t_lost [N];
    int s_beat [N], s_last [N], s_done [N], s_to [N], s_lost [N], s_req [N], s_acc [N];
    logic [N-1:0] req_p = '0, gnt_p = '0, ready_p = '0, beat_p = '0;

    task automatic expect_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic snap();
        s_beat = n_beat; s_last = n_last; s_done = n_done; s_to = n_to;
        s_lost = n_lost; s_req = n_req; s_acc = n_acc;
    endtask

    task automatic check();
        logic [7:0] ev, gv;
        logic eb;
        @(negedge clk);
        cyc++;
        for (int k = 0; k < N; k++) begin
            eb = ph[k] == 2 && gnt[k];
            ev = {ph[k] == 0, ph[k] == 1 || ph[k] == 2, ph[k] != 0, eb, eb && sent[k] == nlen[k] - 1,
                  pend[k] == 1, pend[k] == 2, pend[k] == 3};
            gv = {cmd_ready[k], req[k], busy[k], beat[k], beat_last[k], done[k], err_to[k], err_lost[k]};
            checks++;
            if (gv !== ev) begin
                errors++;
                $display("FAIL client%0d outputs cycle %0d got %b want %b (ready,req,busy,beat,last,done,to,lost)",
                         k, cyc, gv, ev);
            end
            n_beat[k] += int'(beat[k]);
            n_last[k] += int'(beat_last[k]);
            n_done[k] += int'(done[k]);
            n_to[k]   += int'(err_to[k]);
            n_lost[k] += int'(err_lost[k]);
            n_req[k]  += int'(req[k]);
            n_acc[k]  += int'(cmd_ready[k] && cmd_valid[k]);
            if (req[k] && !req_p[k]) t_req[k] = cyc;
            if (gnt[k] && !gnt_p[k]) t_gnt[k] = cyc;
            if (cmd_ready[k] && !ready_p[k]) t_ready[k] = cyc;
            if (beat[k] && !beat_p[k]) t_beat[k] = cyc;
            if (done[k]) t_done[k] = cyc;
            if (err_lost[k]) t_lost[k] = cyc;
        end
        checks++;
        if ($countones(beat[2:0]) > 1) begin
            errors++;
            $display("FAIL beat overlap cycle %0d got %b want at most one", cyc, beat[2:0]);
        end
        req_p = req; gnt_p = gnt; ready_p = cmd_ready; beat_p = beat;
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int k, input int len);
        snap();
        cmd_valid[k] = 1'b1;
        cmd_len[k] = 4'(len);
        check();
        c0 = cyc;
        cmd_valid[k] = 1'b0;
    endtask

    initial begin
        foreach (cmd_len[k]) cmd_len[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        check();
        expect_int("reset cmd_ready", int'(cmd_ready[0]), 1);
        expect_int("reset req", int'(req[0]), 0);
        expect_int("reset busy", int'(busy[0]), 0);
        resetn = 1'b1;
        check();

        // single uncontended burst
        launch(0, 3);
        repeat (12) check();
        expect_int("t1 req cycle", t_req[0] - c0, 1);
        expect_int("t1 gnt cycle", t_gnt[0] - c0, 2);
        expect_int("t1 first beat", t_beat[0] - c0, 3);
        expect_int("t1 beats", n_beat[0] - s_beat[0], 4);
        expect_int("t1 beat_last", n_last[0] - s_last[0], 1);
        expect_int("t1 done cycle", t_done[0] - c0, 7);
        expect_int("t1 ready cycle", t_ready[0] - c0, 9);

        // three clients contend from the same edge
        snap();
        cmd_valid[2:0] = 3'b111;
        for (int k = 0; k < 3; k++) cmd_len[k] = 4'd1;
        check();
        c0 = cyc;
        cmd_valid[2:0] = 3'b000;
        repeat (20) check();
        expect_int("t2 client0 first beat", t_beat[0] - c0, 3);
        expect_int("t2 client1 first beat", t_beat[1] - c0, 8);
        expect_int("t2 client2 first beat", t_beat[2] - c0, 13);
        for (int k = 0; k < 3; k++) begin
            expect_int($sformatf("t2 client%0d beats", k), n_beat[k] - s_beat[k], 2);
            expect_int($sformatf("t2 client%0d done", k), n_done[k] - s_done[k], 1);
        end

        // grant never arrives
        launch(3, 2);
        repeat (10) check();
        expect_int("t3 req cycles", n_req[3] - s_req[3], 5);
        expect_int("t3 timeouts", n_to[3] - s_to[3], 1);
        expect_int("t3 ready cycle", t_ready[3] - c0, 7);
        expect_int("t3 beats", n_beat[3] - s_beat[3], 0);

        // grant withdrawn after two beats
        launch(0, 7);
        repeat (4) check();
        frc_en = 1'b1;
        frc_val = 1'b0;
        repeat (6) check();
        frc_en = 1'b0;
        repeat (4) check();
        expect_int("t4 beats", n_beat[0] - s_beat[0], 2);
        expect_int("t4 lost pulses", n_lost[0] - s_lost[0], 1);
        expect_int("t4 lost cycle", t_lost[0] - c0, 6);
        expect_int("t4 done", n_done[0] - s_done[0], 0);

        // reset on the second beat
        launch(0, 5);
        repeat (3) check();
        resetn = 1'b0;
        check();
        expect_int("t5 ready after reset", int'(cmd_ready[0]), 1);
        expect_int("t5 req after reset", int'(req[0]), 0);
        expect_int("t5 beat after reset", int'(beat[0]), 0);
        resetn = 1'b1;
        repeat (6) check();
        expect_int("t5 pulses", n_done[0] + n_to[0] + n_lost[0] - s_done[0] - s_to[0] - s_lost[0], 0);

        // single-beat burst
        launch(0, 0);
        repeat (8) check();
        expect_int("t6 len0 beats", n_beat[0] - s_beat[0], 1);
        expect_int("t6 len0 last", n_last[0] - s_last[0], 1);
        expect_int("t6 len0 done", n_done[0] - s_done[0], 1);

        // longest burst with cmd_valid held and cmd_len changed mid-burst
        snap();
        cmd_valid[0] = 1'b1;
        cmd_len[0] = 4'd15;
        check();
        c0 = cyc;
        cmd_len[0] = 4'd4;
        repeat (15) check();
        cmd_valid[0] = 1'b0;
        repeat (12) check();
        expect_int("t6 len15 beats", n_beat[0] - s_beat[0], 16);
        expect_int("t6 len15 last", n_last[0] - s_last[0], 1);
        expect_int("t6 accepts", n_acc[0] - s_acc[0], 1);
        expect_int("t6 done cycle", t_done[0] - c0, 19);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
